// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch sequencer and the decode stage it feeds.
// State encodings are fixed because seq_state is exported for debug.
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        BOOT     = 3'd0,
        RUN      = 3'd1,
        LU_STALL = 3'd2,
        REDIRECT = 3'd3,
        FLUSH    = 3'd4,
        HALT     = 3'd5
    } seq_state_t;

    localparam logic [15:0] RESET_VEC_DEFAULT = 16'h0008;

    // Decode substitutes this for ins while bubble is high
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with enable and synchronous clear (clear wins).
// Latency: count visible one cycle after the enabled edge; no backpressure.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: turns decode jump/load-use/halt requests into PC/IR controls and bubbles.
// Latency: requests sampled at an edge act on the following cycle; all outputs are Moore.
// Optional FETCH_SEQ_PERF_EN adds saturating stall_cnt / flush_cnt performance counters.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int                 ADDR_W       = 16,
    parameter logic [ADDR_W-1:0]  RESET_VEC    = ADDR_W'(RESET_VEC_DEFAULT),
    parameter int                 FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jmp_req,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              load_use,
    input  logic              halt_req,
    input  logic              resume,
    output logic              pc_mux_sel,
    output logic [ADDR_W-1:0] jmp_loc,
    output logic              stall,
    output logic              stall_pm,
    output logic              bubble,
    output logic [2:0]        seq_state
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] jmp_loc_q, jmp_loc_d;
    logic [2:0]        fcnt_q, fcnt_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= BOOT;
            jmp_loc_q <= RESET_VEC;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            jmp_loc_q <= jmp_loc_d;
            fcnt_q    <= fcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        jmp_loc_d  = jmp_loc_q;
        fcnt_d     = fcnt_q;
        pc_mux_sel = 1'b0;
        stall      = 1'b0;
        stall_pm   = 1'b0;
        bubble     = 1'b0;

        case (state_q)
            BOOT: begin
                pc_mux_sel = 1'b1;
                bubble     = 1'b1;
                state_d    = RUN;
            end
            RUN, LU_STALL: begin
                if (state_q == LU_STALL) begin
                    stall    = 1'b1;
                    stall_pm = 1'b1;
                    bubble   = 1'b1;
                end
                if (halt_req) begin
                    state_d = HALT;
                end else if (jmp_req) begin
                    state_d   = REDIRECT;
                    jmp_loc_d = jmp_target;
                end else if (load_use) begin
                    state_d = LU_STALL;
                end else begin
                    state_d = RUN;
                end
            end
            REDIRECT: begin
                pc_mux_sel = 1'b1;
                bubble     = 1'b1;
                state_d    = FLUSH;
                fcnt_d     = FLUSH_LOAD;
            end
            FLUSH: begin
                // load_use is dropped here: the flushed slot never reaches execute
                bubble = 1'b1;
                if (halt_req) begin
                    state_d = HALT;
                end else if (jmp_req) begin
                    state_d   = REDIRECT;
                    jmp_loc_d = jmp_target;
                end else if (fcnt_q == 3'd0) begin
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end
            HALT: begin
                stall    = 1'b1;
                stall_pm = 1'b1;
                bubble   = 1'b1;
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign jmp_loc   = jmp_loc_q;
    assign seq_state = state_q;

`ifdef FETCH_SEQ_PERF_EN
    sat_counter #(.W(32)) u_stall_cnt (
        .clk (clk),
        .clr (!reset),
        .en  (stall),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(32)) u_flush_cnt (
        .clk (clk),
        .clr (!reset),
        .en  (bubble && (state_q != BOOT)),
        .cnt (flush_cnt)
    );
`endif

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control block that sequences the program-memory fetch stage (PC register, PC mux, instruction register). It turns decode-stage hazard, jump and halt requests into the fetch-stage control signals `pc_mux_sel`, `jmp_loc`, `stall` and `stall_pm`. It also issues a `bubble` to decode so that the stage inserts NOPs. It sits between the decode/hazard logic and the program memory module, and is the only driver of those fetch controls.

## Interface
- `ADDR_W`, 16: instruction address width; equals the program memory address width.
- `RESET_VEC`, 16'h0008: address the PC is loaded with out of reset.
- `FLUSH_CYCLES`, 1: number of bubble cycles after a redirect, in the range 1..7.

- `clk`  in  1  single clock for the block; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `jmp_req`  in  1  decode has resolved a taken jump or branch.
- `jmp_target`  in  ADDR_W  target address; valid while `jmp_req`=1.
- `load_use`  in  1  load-use hazard; asserted one cycle before the stall is needed.
- `halt_req`  in  1  freeze fetch.
- `resume`  in  1  leave halt.
- `pc_mux_sel`  out  1  1 = PC loads `jmp_loc`; 0 = PC increments.
- `jmp_loc`  out  ADDR_W  redirect address.
- `stall`  out  1  hold the PC.
- `stall_pm`  out  1  hold the instruction register (re-present the previous `ins`).
- `bubble`  out  1  decode substitutes a NOP for the current `ins`.
- `seq_state`  out  3  current state, for debug.

## Operation
- All outputs are Moore outputs, decoded from the registered state plus the registered `jmp_loc`.
- **States:** BOOT, RUN, LU_STALL, REDIRECT, FLUSH, HALT.
- **Reset** (`reset`=0 at an edge): state=BOOT, `pc_mux_sel`=1, `jmp_loc`=RESET_VEC, `stall`=0, `stall_pm`=0, `bubble`=1, flush counter=0.
  - These values hold for every cycle `reset` stays low, so the PC continuously reloads RESET_VEC.
- **BOOT:** go to RUN unconditionally; outputs are as in reset.
- **Request priority,** sampled in RUN, LU_STALL and FLUSH: `halt_req` > `jmp_req` > `load_use`.
- **RUN:** all outputs 0.
  - `halt_req` → HALT.
  - `jmp_req` → REDIRECT and latch `jmp_target` into `jmp_loc`.
  - `load_use` → LU_STALL.
- **LU_STALL:** `stall`=1, `stall_pm`=1, `bubble`=1.
  - Stays in LU_STALL while `load_use`=1; otherwise → RUN.
  - `jmp_req` in this state → REDIRECT, and the load-use condition is discarded.
- **REDIRECT** (exactly 1 cycle): `pc_mux_sel`=1, `bubble`=1, `stall`=0. Then → FLUSH, with the counter loaded to FLUSH_CYCLES−1.
- **FLUSH:** `bubble`=1; other outputs 0.
  - Counter decrements each cycle; → RUN after the cycle in which it reads 0.
  - A new `jmp_req` restarts REDIRECT with the new target.
  - `load_use` is ignored.
- **HALT:** `stall`=1, `stall_pm`=1, `bubble`=1.
  - `resume`=1 → RUN.
  - `jmp_req` and `load_use` are ignored.
  - `halt_req` and `resume` both high → RUN, which gives exactly one cycle of progress.
- `jmp_loc` keeps its last value outside REDIRECT; it is only meaningful while `pc_mux_sel`=1.

## Timing
- Request sampled at edge N → output change visible after edge N (1-cycle latency).
- **Jump:** `jmp_req` at edge N.
  - `pc_mux_sel`=1 during cycle N..N+1.
  - The PC holds the target after edge N+1.
  - `bubble` lasts 1+FLUSH_CYCLES cycles in total.
- **Load-use:** each cycle of `load_use` gives one cycle of stall.
- **Reset mid-operation:** any state → BOOT at the next edge. Counters clear; the latched target is lost.

## Configuration
- `FETCH_SEQ_PERF_EN` defined:
  - Adds outputs `stall_cnt` [31:0] (cycles with `stall`=1) and `flush_cnt` [31:0] (cycles with `bubble`=1 outside BOOT).
  - Both are saturating at 32'hFFFF_FFFF and cleared by reset.
- Not defined: those ports and the counter logic are absent; all other behaviour is identical.

## Structure
- **Package `fetch_seq_pkg`:**
  - state enum with encodings BOOT=0, RUN=1, LU_STALL=2, REDIRECT=3, FLUSH=4, HALT=5;
  - default RESET_VEC;
  - NOP instruction constant 32'h0000_0000 used by decode.
- **Sub-module:** one `sat_counter` (32-bit, enable, sync clear), instantiated twice, only under `FETCH_SEQ_PERF_EN`.

## Test plan
- Hold `reset`=0 for 3 cycles, then release → `pc_mux_sel`=1 and `jmp_loc`=16'h0008 during reset. One BOOT cycle follows, then RUN with all outputs 0.
- In RUN, pulse `load_use` for 2 cycles → `stall`=`stall_pm`=`bubble`=1 for exactly 2 cycles, then 0.
- With FLUSH_CYCLES=2, pulse `jmp_req` with `jmp_target`=16'h0040 → 1 cycle of `pc_mux_sel`=1 and `jmp_loc`=16'h0040, then 2 further `bubble` cycles, then RUN.
- Drive `jmp_req`=1, `load_use`=1 and `halt_req`=0 in the same cycle → REDIRECT, no stall. Repeat with `halt_req`=1 → HALT, and `jmp_loc` unchanged.
- `halt_req` for 1 cycle, wait 4 cycles, then `resume` → `stall`/`stall_pm` high for all 5 cycles, then RUN. With `FETCH_SEQ_PERF_EN`, `stall_cnt`=5.
- Assert `reset`=0 while in FLUSH → BOOT next cycle, `jmp_loc`=RESET_VEC, flush counter cleared.
